// File: rtl/dispatch_queue_allocator.sv
// In-order dispatch queue: buffers decoded entries, snoops writeback ports to
// wake operands, and issues the head to a free ALU, the LS unit or the branch unit.

module dispatch_queue_wake #(
   parameter int XLEN   = 32,
   parameter int TAG_W  = 4,
   parameter int RA_W   = 5,
   parameter int NUM_WB = 3
) (
   input  logic [NUM_WB-1:0]      wb_en,
   input  logic [NUM_WB*RA_W-1:0] wb_addr,
   input  logic [NUM_WB*XLEN-1:0] wb_data,
   input  logic [TAG_W-1:0]       tagx,
   input  logic [TAG_W-1:0]       tagy,
   input  logic [TAG_W-1:0]       tagw,
   input  logic [RA_W-1:0]        addrx,
   input  logic [RA_W-1:0]        addry,
   input  logic [RA_W-1:0]        addrw,
   input  logic [XLEN-1:0]        datax,
   input  logic [XLEN-1:0]        datay,
   output logic [TAG_W-1:0]       wk_tagx,
   output logic [TAG_W-1:0]       wk_tagy,
   output logic [TAG_W-1:0]       wk_tagw,
   output logic [XLEN-1:0]        wk_datax,
   output logic [XLEN-1:0]        wk_datay
);

   // Scan from the highest port down so the lowest matching port wins.
   always_comb begin
      wk_tagx  = tagx;
      wk_tagy  = tagy;
      wk_tagw  = tagw;
      wk_datax = datax;
      wk_datay = datay;
      for (int i = NUM_WB-1; i >= 0; i--) begin
         if (wb_en[i] && tagx != '0 && addrx != '0 && wb_addr[i*RA_W +: RA_W] == addrx) begin
            wk_tagx  = '0;
            wk_datax = wb_data[i*XLEN +: XLEN];
         end
         if (wb_en[i] && tagy != '0 && addry != '0 && wb_addr[i*RA_W +: RA_W] == addry) begin
            wk_tagy  = '0;
            wk_datay = wb_data[i*XLEN +: XLEN];
         end
         if (wb_en[i] && tagw != '0 && addrw != '0 && wb_addr[i*RA_W +: RA_W] == addrw)
            wk_tagw = '0;
      end
   end

endmodule

module dispatch_queue_allocator #(
   parameter int XLEN    = 32,
   parameter int OP_W    = 8,
   parameter int TAG_W   = 4,
   parameter int RA_W    = 5,
   parameter int DEPTH   = 4,
   parameter int NUM_ALU = 2,
   parameter int NUM_WB  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   input  logic                   flush_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [OP_W-1:0]        in_op,
   input  logic [XLEN-1:0]        in_pc,
   input  logic [XLEN-1:0]        in_imm,
   input  logic [XLEN-1:0]        in_datax,
   input  logic [XLEN-1:0]        in_datay,
   input  logic [TAG_W-1:0]       in_tagx,
   input  logic [TAG_W-1:0]       in_tagy,
   input  logic [TAG_W-1:0]       in_tagw,
   input  logic [RA_W-1:0]        in_addrx,
   input  logic [RA_W-1:0]        in_addry,
   input  logic [RA_W-1:0]        in_addrw,
   input  logic [NUM_WB-1:0]      wb_en,
   input  logic [NUM_WB*RA_W-1:0] wb_addr,
   input  logic [NUM_WB*XLEN-1:0] wb_data,
   input  logic [NUM_ALU-1:0]     alu_busy,
   input  logic                   ls_busy,
   input  logic                   br_busy,
   output logic [NUM_ALU-1:0]     alu_en,
   output logic                   ls_en,
   output logic                   br_en,
   output logic [3:0]             iss_op,
   output logic [XLEN-1:0]        iss_pc,
   output logic [XLEN-1:0]        iss_imm,
   output logic [XLEN-1:0]        iss_datax,
   output logic [XLEN-1:0]        iss_datay,
   output logic [TAG_W-1:0]       iss_tagx,
   output logic [TAG_W-1:0]       iss_tagy,
   output logic [TAG_W-1:0]       iss_tagw,
   output logic [RA_W-1:0]        iss_addrx,
   output logic [RA_W-1:0]        iss_addry,
   output logic [RA_W-1:0]        iss_addrw,
   output logic                   ren_en,
   output logic [RA_W-1:0]        ren_addr,
   output logic [TAG_W-1:0]       ren_tag
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  datax;
      logic [XLEN-1:0]  datay;
      logic [TAG_W-1:0] tagx;
      logic [TAG_W-1:0] tagy;
      logic [TAG_W-1:0] tagw;
      logic [RA_W-1:0]  addrx;
      logic [RA_W-1:0]  addry;
      logic [RA_W-1:0]  addrw;
   } entry_t;

   entry_t           q   [DEPTH];
   entry_t           src [DEPTH+1];
   entry_t           wk  [DEPTH+1];
   logic [TAG_W-1:0] wk_tagx  [DEPTH+1];
   logic [TAG_W-1:0] wk_tagy  [DEPTH+1];
   logic [TAG_W-1:0] wk_tagw  [DEPTH+1];
   logic [XLEN-1:0]  wk_datax [DEPTH+1];
   logic [XLEN-1:0]  wk_datay [DEPTH+1];

   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          nonempty, act, push, pop, found;
   logic [3:0]    cls;
   logic          is_alu, is_ls, is_ld, is_br;
   entry_t        h;

   // Slot DEPTH carries the incoming entry so pushes are bypassed like queued ones.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) src[i] = q[i];
      src[DEPTH].op    = in_op;
      src[DEPTH].pc    = in_pc;
      src[DEPTH].imm   = in_imm;
      src[DEPTH].datax = in_datax;
      src[DEPTH].datay = in_datay;
      src[DEPTH].tagx  = in_tagx;
      src[DEPTH].tagy  = in_tagy;
      src[DEPTH].tagw  = in_tagw;
      src[DEPTH].addrx = in_addrx;
      src[DEPTH].addry = in_addry;
      src[DEPTH].addrw = in_addrw;
   end

   for (genvar g = 0; g <= DEPTH; g++) begin : g_wake
      dispatch_queue_wake #(
         .XLEN(XLEN), .TAG_W(TAG_W), .RA_W(RA_W), .NUM_WB(NUM_WB)
      ) u_wake (
         .wb_en   (wb_en),
         .wb_addr (wb_addr),
         .wb_data (wb_data),
         .tagx    (src[g].tagx),
         .tagy    (src[g].tagy),
         .tagw    (src[g].tagw),
         .addrx   (src[g].addrx),
         .addry   (src[g].addry),
         .addrw   (src[g].addrw),
         .datax   (src[g].datax),
         .datay   (src[g].datay),
         .wk_tagx (wk_tagx[g]),
         .wk_tagy (wk_tagy[g]),
         .wk_tagw (wk_tagw[g]),
         .wk_datax(wk_datax[g]),
         .wk_datay(wk_datay[g])
      );
   end

   always_comb begin
      for (int i = 0; i <= DEPTH; i++) begin
         wk[i]       = src[i];
         wk[i].tagx  = wk_tagx[i];
         wk[i].tagy  = wk_tagy[i];
         wk[i].tagw  = wk_tagw[i];
         wk[i].datax = wk_datax[i];
         wk[i].datay = wk_datay[i];
      end
   end

   assign h        = wk[{1'b0, rd_ptr}];
   assign nonempty = (count != '0);
   assign in_ready = (count != CW'(DEPTH));
   assign act      = rdy && !flush_in && nonempty;
   assign push     = in_valid && in_ready && rdy && !flush_in;
   assign cls      = h.op[7:4];

   always_comb begin
      is_alu = (cls == 4'h1) || (cls == 4'h2) || (cls == 4'h5) || (cls == 4'hD);
      is_ld  = (cls == 4'h9);
      is_ls  = (cls == 4'h3) || is_ld;
      is_br  = (cls == 4'h4);
   end

   always_comb begin
      alu_en  = '0;
      ls_en   = 1'b0;
      br_en   = 1'b0;
      ren_en  = 1'b0;
      ren_tag = '0;
      pop     = 1'b0;
      found   = 1'b0;
      if (act) begin
         if (is_alu) begin
            for (int i = 0; i < NUM_ALU; i++) begin
               if (!found && !alu_busy[i]) begin
                  alu_en[i] = 1'b1;
                  ren_en    = 1'b1;
                  ren_tag   = TAG_W'(i + 1);
                  found     = 1'b1;
               end
            end
            pop = found;
         end else if (is_ls) begin
            if (!ls_busy) begin
               ls_en = 1'b1;
               pop   = 1'b1;
               if (is_ld) begin
                  ren_en  = 1'b1;
                  ren_tag = TAG_W'(NUM_ALU + 1);
               end
            end
         end else if (is_br) begin
            if (!br_busy) begin
               br_en = 1'b1;
               pop   = 1'b1;
            end
         end else begin
            pop = 1'b1;
         end
      end
   end

   // Payload reads as zero while empty so stale storage never leaks out.
   always_comb begin
      iss_op    = '0;
      iss_pc    = '0;
      iss_imm   = '0;
      iss_datax = '0;
      iss_datay = '0;
      iss_tagx  = '0;
      iss_tagy  = '0;
      iss_tagw  = '0;
      iss_addrx = '0;
      iss_addry = '0;
      iss_addrw = '0;
      ren_addr  = '0;
      if (nonempty) begin
         iss_op    = h.op[3:0];
         iss_pc    = h.pc;
         iss_imm   = h.imm;
         iss_datax = h.datax;
         iss_datay = h.datay;
         iss_tagx  = h.tagx;
         iss_tagy  = h.tagy;
         iss_tagw  = (is_ls && !is_ld) ? '0 : h.tagw;
         iss_addrx = h.addrx;
         iss_addry = h.addry;
         iss_addrw = h.addrw;
         ren_addr  = h.addrw;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else if (flush_in) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else if (rdy) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= wk[i];
         if (push) begin
            q[wr_ptr] <= wk[DEPTH];
            wr_ptr    <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

endmodule
